// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and
// data access. MEM has priority, IF has a starvation guard, and a watchdog turns a lost ack into an error completion.
module pipe_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // instruction fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  // data access requester
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              err_o,
  // unified memory port
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_ack_i,
  input  logic [DATA_W-1:0] m_rdata_i
);

  // Handshake: a requester holds req/addr/we/wdata until its done pulse; the memory
  // port holds m_req_o and every m_* output stable until the cycle m_ack_i is 1.

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUSY_IF  = 2'd1;
  localparam logic [1:0] ST_BUSY_MEM = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] starve_q;
  logic [7:0] wd_q;

  logic idle;
  logic busy;
  logic if_want;
  logic mem_want;
  logic grant_if;
  logic grant_mem;
  logic ack_hit;
  logic expire;
  logic finish;

  // A requester whose done pulse is high is still presenting the completed request.
  assign if_want  = if_req_i & ~if_done_o;
  assign mem_want = mem_req_i & ~mem_done_o;

  assign idle      = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BUSY_IF) | (state_q == ST_BUSY_MEM);
  assign grant_mem = idle & mem_want & (~if_want | (starve_q != STARVE_MAX));
  assign grant_if  = idle & if_want & ~grant_mem;

  assign ack_hit = busy & m_ack_i;
  assign expire  = busy & ~m_ack_i & (wd_q == WD_LAST);
  assign finish  = ack_hit | expire;

  assign if_stall_o  = if_req_i & ~if_done_o;
  assign mem_stall_o = mem_req_i & ~mem_done_o;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_mem) begin
          state_d = ST_BUSY_MEM;
        end else if (grant_if) begin
          state_d = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (finish) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Watchdog is zero on BUSY entry and counts BUSY cycles that end without an ack.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wd_q <= 8'd0;
    end else if (busy & ~finish) begin
      wd_q <= wd_q + 8'd1;
    end else begin
      wd_q <= 8'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= 4'd0;
    end else if (grant_if) begin
      starve_q <= 4'd0;
    end else if (grant_mem & if_req_i & (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_req_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
    end else if (grant_mem) begin
      m_req_o   <= 1'b1;
      m_we_o    <= mem_we_i;
      m_addr_o  <= mem_addr_i;
      m_wdata_o <= mem_wdata_i;
    end else if (grant_if) begin
      m_req_o   <= 1'b1;
      m_we_o    <= 1'b0;
      m_addr_o  <= if_addr_i;
      m_wdata_o <= '0;
    end else if (finish) begin
      m_req_o <= 1'b0;
    end
  end

  // Read data is only driven during the done pulse; writes and timeouts return zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      if_done_o   <= finish & (state_q == ST_BUSY_IF);
      mem_done_o  <= finish & (state_q == ST_BUSY_MEM);
      err_o       <= expire;
      if_rdata_o  <= (ack_hit & (state_q == ST_BUSY_IF)) ? m_rdata_i : '0;
      mem_rdata_o <= (ack_hit & (state_q == ST_BUSY_MEM) & ~m_we_o) ? m_rdata_i : '0;
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level reference
// model for pipe_mem_arbiter (MAX_STARVE=4, TIMEOUT=8).
module tb_pipe_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4;
  localparam int TO = 8;

  logic          clk_i;
  logic          rst_n_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_done_o;
  logic [DW-1:0] if_rdata_o;
  logic          if_stall_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic          mem_done_o;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_stall_o;
  logic          err_o;
  logic          m_req_o;
  logic          m_we_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic          m_ack_i;
  logic [DW-1:0] m_rdata_i;

  int checks;
  int errors;

  pipe_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o),
    .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .mem_stall_o(mem_stall_o), .err_o(err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_ack_i(m_ack_i), .m_rdata_i(m_rdata_i)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout bench did not finish, got running exp finished");
    $fatal(1, "simulation time limit");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_quiet();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    m_ack_i     = 1'b0;
    m_rdata_i   = '0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    drive_quiet();
    repeat (2) cyc();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i     = 1'b0;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0040;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h0000_0200;
    mem_wdata_i = 32'h0;
    m_ack_i     = 1'b0;
    m_rdata_i   = 32'hFFFF_FFFF;
    repeat (3) cyc();
    checks++;
    if ({m_req_o, m_we_o, if_done_o, mem_done_o, err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000", {m_req_o, m_we_o, if_done_o, mem_done_o, err_o});
    end
    checks++;
    if ({m_addr_o, m_wdata_o, if_rdata_o, mem_rdata_o} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {m_addr_o, m_wdata_o, if_rdata_o, mem_rdata_o});
    end
    rst_n_i = 1'b1;
    cyc();
    checks++;
    if (m_req_o !== 1'b1 || m_addr_o !== 32'h0000_0200) begin
      errors++;
      $display("FAIL reset_first_grant got req=%b addr=%h exp req=1 addr=00000200", m_req_o, m_addr_o);
    end
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h1111_2222;
    cyc();
    checks++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h1111_2222 || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_done got done=%b rdata=%h req=%b exp 1 11112222 0",
               mem_done_o, mem_rdata_o, m_req_o);
    end
    mem_req_i = 1'b0;
    m_ack_i   = 1'b0;
    cyc();
    checks++;
    if (m_req_o !== 1'b1 || m_addr_o !== 32'h0000_0040) begin
      errors++;
      $display("FAIL reset_if_after got req=%b addr=%h exp req=1 addr=00000040", m_req_o, m_addr_o);
    end
    m_ack_i = 1'b1;
    cyc();
    if_req_i = 1'b0;
    m_ack_i  = 1'b0;
    cyc();
  endtask

  task automatic test_if_read();
    int stall_cnt;
    stall_cnt = 0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0040;
    #1;
    if (if_stall_o === 1'b1) stall_cnt++;
    cyc();
    checks++;
    if (m_req_o !== 1'b1 || m_addr_o !== 32'h40 || m_we_o !== 1'b0 || m_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL if_read_grant got req=%b addr=%h we=%b wdata=%h exp 1 00000040 0 0",
               m_req_o, m_addr_o, m_we_o, m_wdata_o);
    end
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h8C22_0004;
    #1;
    if (if_stall_o === 1'b1) stall_cnt++;
    checks++;
    if (if_done_o !== 1'b0) begin
      errors++;
      $display("FAIL if_read_early_done got %b exp 0", if_done_o);
    end
    cyc();
    checks++;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'h8C22_0004 || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL if_read_done got done=%b rdata=%h req=%b exp 1 8c220004 0",
               if_done_o, if_rdata_o, m_req_o);
    end
    m_ack_i   = 1'b0;
    m_rdata_i = 32'h0;
    #1;
    if (if_stall_o === 1'b1) stall_cnt++;
    checks++;
    if (stall_cnt !== 2) begin
      errors++;
      $display("FAIL if_read_stall_cycles got %0d exp 2", stall_cnt);
    end
    // request still held through the done cycle must not be reissued
    cyc();
    checks++;
    if (if_done_o !== 1'b0 || m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL if_read_masked got done=%b req=%b exp 0 0", if_done_o, m_req_o);
    end
    if_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_mem_write_wait();
    int req_cnt;
    req_cnt     = 0;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_addr_i  = 32'h0000_0100;
    mem_wdata_i = 32'hDEAD_BEEF;
    if_req_i    = 1'b1;
    if_addr_i   = 32'h0000_0080;
    cyc();
    for (int b = 1; b <= 4; b++) begin
      checks++;
      if (m_req_o !== 1'b1 || m_addr_o !== 32'h100 || m_we_o !== 1'b1 ||
          m_wdata_o !== 32'hDEAD_BEEF || mem_done_o !== 1'b0 || if_stall_o !== 1'b1) begin
        errors++;
        $display("FAIL mem_wr_busy%0d got req=%b addr=%h we=%b wd=%h done=%b istall=%b exp 1 00000100 1 deadbeef 0 1",
                 b, m_req_o, m_addr_o, m_we_o, m_wdata_o, mem_done_o, if_stall_o);
      end
      if (m_req_o === 1'b1) req_cnt++;
      if (b == 4) begin
        m_ack_i   = 1'b1;
        m_rdata_i = 32'h1234_5678;
      end
      cyc();
    end
    checks++;
    if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h0 || m_req_o !== 1'b0 || if_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL mem_wr_done got done=%b rdata=%h req=%b istall=%b exp 1 0 0 1",
               mem_done_o, mem_rdata_o, m_req_o, if_stall_o);
    end
    checks++;
    if (req_cnt !== 4) begin
      errors++;
      $display("FAIL mem_wr_req_cycles got %0d exp 4", req_cnt);
    end
    mem_req_i = 1'b0;
    m_ack_i   = 1'b0;
    cyc();
    checks++;
    if (m_req_o !== 1'b1 || m_addr_o !== 32'h80 || m_we_o !== 1'b0 || m_wdata_o !== 32'h0) begin
      errors++;
      $display("FAIL mem_wr_if_next got req=%b addr=%h we=%b wd=%h exp 1 00000080 0 0",
               m_req_o, m_addr_o, m_we_o, m_wdata_o);
    end
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h0BAD_F00D;
    cyc();
    checks++;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mem_wr_if_done got done=%b rdata=%h exp 1 0badf00d", if_done_o, if_rdata_o);
    end
    drive_quiet();
    cyc();
  endtask

  // Both requesters re-request immediately; the done-cycle mask alternates grants.
  task automatic test_contention();
    logic [AW-1:0] exp_addr;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_1000;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_2000;
    for (int k = 0; k < 6; k++) begin
      cyc();
      exp_addr = (k % 2 == 0) ? 32'h2000 + 32'(4 * (k / 2)) : 32'h1000 + 32'(4 * (k / 2));
      checks++;
      if (m_req_o !== 1'b1 || m_addr_o !== exp_addr) begin
        errors++;
        $display("FAIL contention_grant%0d got req=%b addr=%h exp 1 %h", k, m_req_o, m_addr_o, exp_addr);
      end
      m_ack_i   = 1'b1;
      m_rdata_i = 32'hC0DE_0000 + 32'(k);
      cyc();
      checks++;
      if ({if_done_o, mem_done_o} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL contention_done%0d got if=%b mem=%b exp %s", k, if_done_o, mem_done_o,
                 (k % 2 == 0) ? "mem" : "if");
      end
      m_ack_i = 1'b0;
      if (k % 2 == 0) mem_addr_i = mem_addr_i + 32'd4;
      else            if_addr_i  = if_addr_i + 32'd4;
      if (k == 5) begin
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
      end
    end
    cyc();
    checks++;
    if (m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle got req=%b exp 0", m_req_o);
    end
    drive_quiet();
  endtask

  task automatic test_timeout();
    for (int v = 0; v < 2; v++) begin
      mem_req_i  = 1'b1;
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h0000_0300;
      m_rdata_i  = 32'hBAD0_BAD0;
      cyc();
      for (int b = 1; b <= TO; b++) begin
        checks++;
        if (m_req_o !== 1'b1 || mem_done_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_v%0d_busy%0d got req=%b done=%b exp 1 0", v, b, m_req_o, mem_done_o);
        end
        if (v == 1 && b == TO) begin
          m_ack_i   = 1'b1;
          m_rdata_i = 32'hA5A5_5A5A;
        end
        cyc();
      end
      checks++;
      if (v == 0) begin
        if (mem_done_o !== 1'b1 || err_o !== 1'b1 || mem_rdata_o !== 32'h0 || m_req_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_expire got done=%b err=%b rdata=%h req=%b exp 1 1 0 0",
                   mem_done_o, err_o, mem_rdata_o, m_req_o);
        end
      end else begin
        if (mem_done_o !== 1'b1 || err_o !== 1'b0 || mem_rdata_o !== 32'hA5A5_5A5A || m_req_o !== 1'b0) begin
          errors++;
          $display("FAIL timeout_ack_wins got done=%b err=%b rdata=%h req=%b exp 1 0 a5a55a5a 0",
                   mem_done_o, err_o, mem_rdata_o, m_req_o);
        end
      end
      drive_quiet();
      cyc();
      checks++;
      if (err_o !== 1'b0 || mem_done_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_v%0d_pulse got err=%b done=%b exp 0 0", v, err_o, mem_done_o);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0500;
    cyc();
    cyc();
    checks++;
    if (m_req_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy got req=%b exp 1", m_req_o);
    end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (m_req_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got req=%b exp 0", m_req_o);
    end
    if_req_i = 1'b0;
    cyc();
    cyc();
    rst_n_i   = 1'b1;
    m_ack_i   = 1'b1;
    m_rdata_i = 32'h7777_7777;
    for (int c = 0; c < 4; c++) begin
      cyc();
      checks++;
      if ({if_done_o, mem_done_o, err_o, m_req_o} !== 4'b0) begin
        errors++;
        $display("FAIL midrst_quiet%0d got %b exp 0000", c, {if_done_o, mem_done_o, err_o, m_req_o});
      end
    end
    drive_quiet();
    cyc();
  endtask

  // Reference model: one outstanding transaction, owner 0 = none, 1 = IF, 2 = MEM.
  task automatic test_random();
    int            owner;
    int            age;
    int            starve;
    bit            noack;
    bit            iw;
    bit            mw;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_if_done, e_mem_done, e_err;
    logic [DW-1:0] e_if_rdata, e_mem_rdata;
    logic          n_if_done, n_mem_done, n_err;
    logic [DW-1:0] n_if_rdata, n_mem_rdata;
    do_reset();
    owner = 0; age = 0; starve = 0; noack = 1'b0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_if_done = 1'b0; e_mem_done = 1'b0; e_err = 1'b0;
    e_if_rdata = '0; e_mem_rdata = '0;
    for (int c = 0; c < 3000 && errors < 30; c++) begin
      checks++;
      if (m_req_o !== (owner != 0) || m_addr_o !== e_addr || m_we_o !== e_we || m_wdata_o !== e_wdata) begin
        errors++;
        $display("FAIL rand_mport c%0d got req=%b addr=%h we=%b wd=%h exp %b %h %b %h",
                 c, m_req_o, m_addr_o, m_we_o, m_wdata_o, (owner != 0), e_addr, e_we, e_wdata);
      end
      checks++;
      if (if_done_o !== e_if_done || mem_done_o !== e_mem_done || err_o !== e_err ||
          if_rdata_o !== e_if_rdata || mem_rdata_o !== e_mem_rdata) begin
        errors++;
        $display("FAIL rand_done c%0d got if=%b mem=%b err=%b ir=%h mr=%h exp %b %b %b %h %h",
                 c, if_done_o, mem_done_o, err_o, if_rdata_o, mem_rdata_o,
                 e_if_done, e_mem_done, e_err, e_if_rdata, e_mem_rdata);
      end
      if (e_if_done) begin
        if ($urandom_range(0, 1) == 0) if_req_i = 1'b0;
        else if_addr_i = $urandom;
      end else if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = $urandom;
      end
      if (e_mem_done || (!mem_req_i && $urandom_range(0, 2) == 0)) begin
        mem_req_i   = e_mem_done ? ($urandom_range(0, 1) == 1) : 1'b1;
        mem_we_i    = $urandom_range(0, 1) == 1;
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
      end
      m_rdata_i = $urandom;
      if (owner != 0) m_ack_i = noack ? 1'b0 : ($urandom_range(0, 2) == 0);
      else            m_ack_i = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (if_stall_o !== (if_req_i & ~e_if_done) || mem_stall_o !== (mem_req_i & ~e_mem_done)) begin
        errors++;
        $display("FAIL rand_stall c%0d got if=%b mem=%b exp %b %b", c, if_stall_o, mem_stall_o,
                 (if_req_i & ~e_if_done), (mem_req_i & ~e_mem_done));
      end
      n_if_done = 1'b0; n_mem_done = 1'b0; n_err = 1'b0;
      n_if_rdata = '0; n_mem_rdata = '0;
      if (owner == 0) begin
        iw = if_req_i && !e_if_done;
        mw = mem_req_i && !e_mem_done;
        if (mw && (!iw || starve != MS)) begin
          owner = 2; age = 1;
          e_addr = mem_addr_i; e_we = mem_we_i; e_wdata = mem_wdata_i;
          if (if_req_i && starve < MS) starve++;
          noack = ($urandom_range(0, 9) == 0);
        end else if (iw) begin
          owner = 1; age = 1;
          e_addr = if_addr_i; e_we = 1'b0; e_wdata = '0;
          starve = 0;
          noack = ($urandom_range(0, 9) == 0);
        end
      end else if (m_ack_i) begin
        if (owner == 1) begin
          n_if_done = 1'b1; n_if_rdata = m_rdata_i;
        end else begin
          n_mem_done = 1'b1; n_mem_rdata = e_we ? '0 : m_rdata_i;
        end
        owner = 0;
      end else if (age == TO) begin
        if (owner == 1) n_if_done = 1'b1;
        else            n_mem_done = 1'b1;
        n_err = 1'b1;
        owner = 0;
      end else begin
        age++;
      end
      e_if_done = n_if_done; e_mem_done = n_mem_done; e_err = n_err;
      e_if_rdata = n_if_rdata; e_mem_rdata = n_mem_rdata;
      @(posedge clk_i);
      #1;
    end
    drive_quiet();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n_i = 1'b0;
    drive_quiet();
    test_reset();
    test_if_read();
    test_mem_write_wait();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
